// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: widths, the FIFO entry layout,
// the fetch FSM states and the opcode encodings used by later stages.
package fetch_pkg;

    localparam int ADDR_W      = 8;
    localparam int INSTR_W     = 16;
    localparam int FETCH_DEPTH = 2;

    // Opcode field encodings (top three bits of the instruction word).
    // Fetch passes instructions through untouched; these are for decode/execute.
    localparam logic [2:0] OP_LDR = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b100;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^ADDR_W with no overflow indication.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, instr} entries. Flush empties it in one cycle
// and takes priority over push/pop. A push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = FETCH_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_r;
    logic               empty_r;

    logic               do_push_s;
    logic               do_pop_s;
    logic [CNT_W-1:0]   count_next_s;

    // Qualify push/pop against occupancy and work out the next entry count.
    always_comb begin
        do_pop_s     = pop & ~empty_r;
        do_push_s    = push & (~full_r | do_pop_s);
        count_next_s = count_r;
        if (flush) begin
            count_next_s = CNT_W'(0);
        end else if (do_push_s & ~do_pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (~do_push_s & do_pop_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            empty_r <= (count_next_s == CNT_W'(0));
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s & ~flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address, and queues
// {pc, instruction} pairs for decode. Branch redirects flush the queue and
// restart fetching at the new target on the following cycle.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int  DEPTH = FETCH_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    fetch_state_t       state_r;
    fetch_state_t       state_next_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_next_s;

    logic               push_s;
    logic               pop_s;
    fetch_entry_t       wr_entry_s;
    fetch_entry_t       head_s;
    logic [CNT_W-1:0]   count_s;
    logic               full_s;
    logic               empty_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state follows fetch_en only; redirects never move the FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fetch_en) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!fetch_en) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake: deliver the head when decode is ready, fetch when there is
    // room (or room is being made by this cycle's pop) and no redirect is due.
    always_comb begin
        pop_s  = instr_ready & ~empty_s;
        push_s = (state_r == RUN) & fetch_en & ~redirect_valid & (~full_s | pop_s);
    end

    // Next PC: a redirect wins over sequential advance; otherwise hold.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
            pc_next_s = redirect_pc;
        end else if (push_s) begin
            pc_next_s = pc_incr(pc_r);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign wr_entry_s = '{pc: pc_r, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .din   (wr_entry_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign imem_addr   = pc_r;
    assign instr_valid = (count_s != CNT_W'(0));
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the instruction memory's 8-bit address, captures the combinationally read 16-bit instruction word, and hands {pc, instruction} pairs to decode through a small prefetch FIFO with a valid/ready handshake. It sits between the PC/instruction memory and the decode stage. It absorbs decode back-pressure without losing instructions and accepts branch redirects (e.g. a taken beq) from execute, flushing everything fetched down the wrong path.

## Interface
- ADDR_W, 8, instruction address width (PC width).
- INSTR_W, 16, instruction word width.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch permitted; low stops new fetches; the FIFO still drains.
- imem_addr  out  ADDR_W  address to instruction memory; equals the PC register.
- imem_rdata  in  INSTR_W  instruction memory read data; combinational from imem_addr.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  INSTR_W  instruction at the FIFO head.
- instr_pc  out  ADDR_W  PC of the FIFO head.
- redirect_valid  in  1  one-cycle request to flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address.

## Operation
- State: pc register, FIFO (count 0..DEPTH, rd/wr pointers), FSM {IDLE, RUN}.
- FSM:
  - IDLE → RUN when fetch_en = 1.
  - RUN → IDLE when fetch_en = 0.
  - redirect_valid does not change the FSM state.
- pop = instr_valid & instr_ready.
- push = (state == RUN) & fetch_en & !redirect_valid & (count < DEPTH | pop).
- On push: write {pc, imem_rdata} at wr pointer, then pc ← pc + 1.
  - pc arithmetic is modulo 2^ADDR_W, so 8'hFF wraps to 8'h00. No overflow flag.
- On redirect_valid:
  - FIFO count ← 0 and pointers reset, regardless of push/pop that cycle.
  - pc ← redirect_pc.
  - An instruction popped in the same cycle counts as delivered; the redirect source discards it if required.
- Push and pop in the same cycle: count is unchanged. This is allowed when full, because pop frees the slot.
- instr/instr_pc show the FIFO head. When instr_valid = 0 they hold their last value; decode must ignore them.
- instr_valid = (count != 0).
- No instruction decoding is done here; opcode fields are passed through untouched.

## Timing
- Reset values: pc = 0, imem_addr = 0, count = 0, instr_valid = 0, instr = 0, instr_pc = 0, state = IDLE.
- Reset asserted mid-operation clears all state immediately (asynchronous); the first fetch after deassertion is from address 0.
- Fetch latency: the word at imem_addr in cycle N is at the FIFO head (instr_valid = 1) in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle with instr_ready held high.
- Redirect latency:
  - redirect_valid in cycle N → imem_addr = redirect_pc in N+1 → instr_valid with that instruction in N+2.
  - instr_valid = 0 in N+1.
- fetch_en low in cycle N: no push in N. Resuming is possible from N+1; the IDLE→RUN transition costs one extra cycle.
- Full FIFO with instr_ready = 0: pc and imem_addr hold steady and no entries are overwritten.

## Structure
- Shared package fetch_pkg:
  - ADDR_W and INSTR_W constants.
  - fetch_entry_t struct {pc, instr}.
  - fetch_state_t enum {IDLE, RUN}.
  - Opcode constants for other stages, e.g. OP_BEQ = 3'b100 and OP_LDR = 3'b010.
- Sub-module fetch_fifo:
  - Parameterized synchronous FIFO of fetch_entry_t.
  - Async reset; push, pop, flush inputs; head, count, full, empty outputs.
- Top-level instruction_fetch holds pc, the FSM and the push/redirect logic.

## Test plan
- Reset, fetch_en = 1, instr_ready = 1, memory {0: 16'h4A4A, 1: 16'h9802, 2: 16'h2D05}:
  - instr_pc 0,1,2 delivered on consecutive cycles starting one cycle after the first fetch.
  - instr values match the memory contents.
- instr_ready = 0 for 5 cycles:
  - exactly DEPTH = 2 entries buffered and imem_addr frozen at 2.
  - On release, PCs 0,1,2,3 delivered in order with no duplicates or gaps.
- redirect_valid with redirect_pc = 8'h04 while the FIFO holds PCs 1,2:
  - instr_valid = 0 the next cycle.
  - The next delivered instr_pc is 4, then 5.
- pc preloaded via redirect to 8'hFE, free-running: delivered PCs are FE, FF, 00, 01.
- fetch_en dropped with 2 entries buffered:
  - both entries drain, then instr_valid = 0.
  - imem_addr is unchanged until fetch_en returns.
- rst asserted mid-stream while full:
  - instr_valid = 0 and imem_addr = 0 immediately.
  - After release, the first delivered instr_pc = 0.
